// File: rtl/cr_huf_comp_sym_cnt_pkg.sv
// Shared types for the Huffman symbol-run counter: run/beat records and the eob position enum.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

package cr_huf_compPKG;

  localparam int SC_DAT_WIDTH   = 10;
  localparam int SC_CNT_WIDTH   = 3;
  localparam int SC_SEQID_WIDTH = `CREOLE_HC_SEQID_WIDTH;
  localparam logic [SC_CNT_WIDTH-1:0] SC_CNT_MAX = SC_CNT_WIDTH'(2**SC_CNT_WIDTH - 1);

  typedef enum logic [1:0] {
    MIDDLE    = 2'd0,
    END       = 2'd1,
    PASS_THRU = 2'd2,
    TRUNC     = 2'd3
  } e_pipe_eob;

  typedef struct packed {
    logic [SC_DAT_WIDTH-1:0] sym;
    logic [SC_CNT_WIDTH-1:0] cnt;
  } s_sc_run;

  typedef struct packed {
    logic [3:0]                vld;
    s_sc_run [3:0]             run;
    logic [SC_SEQID_WIDTH-1:0] seq_id;
    e_pipe_eob                 eob;
  } s_sc_beat;

endpackage

// File: rtl/cr_huf_comp_sym_cnt_fifo.sv
// Output beat FIFO; the head reads as all-zero while empty so the downstream sees clean idle values.
module cr_huf_comp_sym_cnt_fifo
  import cr_huf_compPKG::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  s_sc_beat      push_data,
  input  logic          pop,
  output s_sc_beat      head,
  output logic          full,
  output logic [CW-1:0] free
);

  s_sc_beat        mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign free    = CW'(DEPTH) - count;
  assign do_pop  = pop && (count != '0);
  // a pop frees the slot the same cycle, so push into a full FIFO is fine then
  assign do_push = push && (!full || do_pop);
  assign head    = (count == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cr_huf_comp_sym_cnt.sv
// Coalesces up to four symbols per cycle into (symbol, count) runs and emits 4-lane run beats.
// Define CR_HUF_COMP_SYM_CNT_STATS_EN to add the sc_stat_sym / sc_stat_sat counters.
module cr_huf_comp_sym_cnt
  import cr_huf_compPKG::*;
#(
  parameter int DAT_WIDTH      = SC_DAT_WIDTH,
  parameter int CNT_WIDTH      = SC_CNT_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int NUM_IN_SYMBOLS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                in_vld,
  input  logic [DAT_WIDTH-1:0]      in_sym0,
  input  logic [DAT_WIDTH-1:0]      in_sym1,
  input  logic [DAT_WIDTH-1:0]      in_sym2,
  input  logic [DAT_WIDTH-1:0]      in_sym3,
  input  logic [SC_SEQID_WIDTH-1:0] in_seq_id,
  input  e_pipe_eob                 in_eob,
  output logic                      in_rdy,
  input  logic                      is_sc_rd,
  output logic [3:0]                sc_is_vld,
  output logic [DAT_WIDTH-1:0]      sc_is_sym0,
  output logic [DAT_WIDTH-1:0]      sc_is_sym1,
  output logic [DAT_WIDTH-1:0]      sc_is_sym2,
  output logic [DAT_WIDTH-1:0]      sc_is_sym3,
  output logic [CNT_WIDTH-1:0]      sc_is_cnt0,
  output logic [CNT_WIDTH-1:0]      sc_is_cnt1,
  output logic [CNT_WIDTH-1:0]      sc_is_cnt2,
  output logic [CNT_WIDTH-1:0]      sc_is_cnt3,
  output logic [SC_SEQID_WIDTH-1:0] sc_is_seq_id,
  output e_pipe_eob                 sc_is_eob
`ifdef CR_HUF_COMP_SYM_CNT_STATS_EN
  ,
  output logic [31:0]               sc_stat_sym,
  output logic [31:0]               sc_stat_sat
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DAT_WIDTH-1:0] sym_in [4];
  s_sc_run   pend_q, pend_d;
  logic      pend_vld_q, pend_vld_d;
  s_sc_run   runs [5];
  logic [2:0] n_runs;
  s_sc_beat  beat_a, beat_b;
  logic      push_a, push_b;
  s_sc_beat  s1_a, s1_b;
  logic      s1_a_vld, s1_b_vld;
  logic      is_eob, xfer;
  s_sc_beat  fifo_head;
  logic      fifo_full;
  logic [CW-1:0] fifo_free;
  logic [1:0] s1_pend;
`ifdef CR_HUF_COMP_SYM_CNT_STATS_EN
  logic [2:0] n_sat;
`endif

  assign sym_in  = '{in_sym0, in_sym1, in_sym2, in_sym3};
  assign is_eob  = (in_eob != MIDDLE);
  assign s1_pend = {1'b0, s1_a_vld} + {1'b0, s1_b_vld};
  // a second queued beat blocks input: the new beats would need the slot it still occupies
  assign in_rdy  = !rst && !s1_b_vld && !fifo_full &&
                   (int'(fifo_free) >= int'(s1_pend) + 2);
  assign xfer    = in_rdy && ((|in_vld) || is_eob);

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    n_runs     = '0;
    beat_a     = '0;
    beat_b     = '0;
    push_a     = 1'b0;
    push_b     = 1'b0;
`ifdef CR_HUF_COMP_SYM_CNT_STATS_EN
    n_sat      = '0;
`endif
    for (int r = 0; r < 5; r++) runs[r] = '0;

    for (int i = 0; i < NUM_IN_SYMBOLS; i++) begin
      if (in_vld[i]) begin
        if (pend_vld_d && sym_in[i] == pend_d.sym && pend_d.cnt != SC_CNT_MAX) begin
          pend_d.cnt = pend_d.cnt + 1'b1;
        end else begin
          if (pend_vld_d) begin
            runs[n_runs] = pend_d;
            n_runs       = n_runs + 3'd1;
`ifdef CR_HUF_COMP_SYM_CNT_STATS_EN
            if (sym_in[i] == pend_d.sym) n_sat = n_sat + 3'd1;
`endif
          end
          pend_d.sym = sym_in[i];
          pend_d.cnt = SC_CNT_WIDTH'(1);
          pend_vld_d = 1'b1;
        end
      end
    end

    if (is_eob) begin
      if (pend_vld_d) begin
        runs[n_runs] = pend_d;
        n_runs       = n_runs + 3'd1;
      end
      pend_d     = '0;
      pend_vld_d = 1'b0;
    end

    beat_a.seq_id = in_seq_id;
    beat_b.seq_id = in_seq_id;
    beat_a.eob    = MIDDLE;
    beat_b.eob    = MIDDLE;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < n_runs) begin
        beat_a.vld[j] = 1'b1;
        beat_a.run[j] = runs[j];
      end
    end
    push_a = (n_runs != 3'd0);

    // the fifth run spills into a second beat, which then owns the eob
    if (n_runs == 3'd5) begin
      beat_b.vld    = 4'b0001;
      beat_b.run[0] = runs[4];
      beat_b.eob    = in_eob;
      push_b        = 1'b1;
    end else if (is_eob) begin
      beat_a.eob = in_eob;
      push_a     = 1'b1;
      if (n_runs == 3'd0) beat_a.vld = 4'b0001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_a_vld   <= 1'b0;
      s1_b_vld   <= 1'b0;
    end else if (xfer) begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      s1_a       <= beat_a;
      s1_a_vld   <= push_a;
      s1_b       <= beat_b;
      s1_b_vld   <= push_b;
    end else begin
      s1_a       <= s1_b;
      s1_a_vld   <= s1_b_vld;
      s1_b_vld   <= 1'b0;
    end
  end

`ifdef CR_HUF_COMP_SYM_CNT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_stat_sym <= '0;
      sc_stat_sat <= '0;
    end else if (xfer) begin
      sc_stat_sym <= sc_stat_sym + 32'($countones(in_vld));
      sc_stat_sat <= sc_stat_sat + {29'd0, n_sat};
    end
  end
`endif

  cr_huf_comp_sym_cnt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s1_a_vld),
    .push_data (s1_a),
    .pop       ((|fifo_head.vld) && is_sc_rd),
    .head      (fifo_head),
    .full      (fifo_full),
    .free      (fifo_free)
  );

  assign sc_is_vld    = fifo_head.vld;
  assign sc_is_sym0   = fifo_head.run[0].sym;
  assign sc_is_sym1   = fifo_head.run[1].sym;
  assign sc_is_sym2   = fifo_head.run[2].sym;
  assign sc_is_sym3   = fifo_head.run[3].sym;
  assign sc_is_cnt0   = fifo_head.run[0].cnt;
  assign sc_is_cnt1   = fifo_head.run[1].cnt;
  assign sc_is_cnt2   = fifo_head.run[2].cnt;
  assign sc_is_cnt3   = fifo_head.run[3].cnt;
  assign sc_is_seq_id = fifo_head.seq_id;
  assign sc_is_eob    = fifo_head.eob;

endmodule

// File: tb/tb_cr_huf_comp_sym_cnt.sv
// Directed bench for cr_huf_comp_sym_cnt with hand-computed run beats.
module tb_cr_huf_comp_sym_cnt;
  import cr_huf_compPKG::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_vld = '0;
  logic [9:0] in_sym0 = '0, in_sym1 = '0, in_sym2 = '0, in_sym3 = '0;
  logic [7:0] in_seq_id = '0;
  e_pipe_eob  in_eob = MIDDLE;
  logic       in_rdy;
  logic       is_sc_rd = 1'b0;
  logic [3:0] sc_is_vld;
  logic [9:0] sc_is_sym0, sc_is_sym1, sc_is_sym2, sc_is_sym3;
  logic [2:0] sc_is_cnt0, sc_is_cnt1, sc_is_cnt2, sc_is_cnt3;
  logic [7:0] sc_is_seq_id;
  e_pipe_eob  sc_is_eob;
`ifdef CR_HUF_COMP_SYM_CNT_STATS_EN
  logic [31:0] sc_stat_sym, sc_stat_sat;
`endif

  int checks = 0;
  int passed = 0;

  cr_huf_comp_sym_cnt dut (
    .clk(clk), .rst(rst), .in_vld(in_vld),
    .in_sym0(in_sym0), .in_sym1(in_sym1), .in_sym2(in_sym2), .in_sym3(in_sym3),
    .in_seq_id(in_seq_id), .in_eob(in_eob), .in_rdy(in_rdy), .is_sc_rd(is_sc_rd),
    .sc_is_vld(sc_is_vld),
    .sc_is_sym0(sc_is_sym0), .sc_is_sym1(sc_is_sym1), .sc_is_sym2(sc_is_sym2), .sc_is_sym3(sc_is_sym3),
    .sc_is_cnt0(sc_is_cnt0), .sc_is_cnt1(sc_is_cnt1), .sc_is_cnt2(sc_is_cnt2), .sc_is_cnt3(sc_is_cnt3),
    .sc_is_seq_id(sc_is_seq_id), .sc_is_eob(sc_is_eob)
`ifdef CR_HUF_COMP_SYM_CNT_STATS_EN
    , .sc_stat_sym(sc_stat_sym), .sc_stat_sat(sc_stat_sat)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // {vld, sym0..3, cnt0..3, seq_id, eob}
  function automatic logic [65:0] obs();
    return {sc_is_vld, sc_is_sym0, sc_is_sym1, sc_is_sym2, sc_is_sym3,
            sc_is_cnt0, sc_is_cnt1, sc_is_cnt2, sc_is_cnt3, sc_is_seq_id, sc_is_eob};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [9:0] s0, input logic [9:0] s1,
                       input logic [9:0] s2, input logic [9:0] s3,
                       input logic [7:0] seq, input e_pipe_eob e);
    int t = 0;
    while (!in_rdy && t < 20) begin
      step();
      t++;
    end
    if (!in_rdy) begin
      checks++;
      $display("FAIL drive_timeout in_rdy=%b required 1", in_rdy);
    end
    in_vld = v; in_sym0 = s0; in_sym1 = s1; in_sym2 = s2; in_sym3 = s3;
    in_seq_id = seq; in_eob = e;
    step();
    in_vld = '0; in_eob = MIDDLE;
  endtask

  task automatic pop_one();
    is_sc_rd = 1'b1;
    step();
    is_sc_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (in_rdy !== 1'b0) $display("FAIL rst_in_rdy got=%b exp=0", in_rdy); else passed++;
    checks++; if (obs() !== 66'd0) $display("FAIL rst_outputs got=%h exp=0", obs()); else passed++;
    rst = 1'b0;
    step();
    checks++; if (in_rdy !== 1'b1) $display("FAIL post_rst_in_rdy got=%b exp=1", in_rdy); else passed++;
    checks++; if (obs() !== 66'd0) $display("FAIL post_rst_outputs got=%h exp=0", obs()); else passed++;
  endtask

  task automatic test_run_split();
    logic [65:0] exp;
    drive(4'b1111, 10'd5, 10'd5, 10'd5, 10'd5, 8'd1, MIDDLE);
    step();
    checks++; if (obs() !== 66'd0) $display("FAIL t1_no_output got=%h exp=0", obs()); else passed++;
    drive(4'b1111, 10'd5, 10'd5, 10'd5, 10'd9, 8'd1, END);
    step();
    exp = {4'b0011, 10'd5, 10'd9, 20'd0, 3'd7, 3'd1, 6'd0, 8'd1, END};
    checks++; if (obs() !== exp) $display("FAIL t1_beat got=%h exp=%h", obs(), exp); else passed++;
    pop_one();
    checks++; if (obs() !== 66'd0) $display("FAIL t1_drained got=%h exp=0", obs()); else passed++;
  endtask

  task automatic test_saturate();
    logic [65:0] exp;
    drive(4'b1111, 10'd3, 10'd3, 10'd3, 10'd3, 8'd2, MIDDLE);
    drive(4'b1111, 10'd3, 10'd3, 10'd3, 10'd3, 8'd2, END);
    step();
    exp = {4'b0011, 10'd3, 10'd3, 20'd0, 3'd7, 3'd1, 6'd0, 8'd2, END};
    checks++; if (obs() !== exp) $display("FAIL t2_sat_beat got=%h exp=%h", obs(), exp); else passed++;
`ifdef CR_HUF_COMP_SYM_CNT_STATS_EN
    checks++; if (sc_stat_sat !== 32'd1) $display("FAIL t2_stat_sat got=%0d exp=1", sc_stat_sat); else passed++;
    checks++; if (sc_stat_sym !== 32'd16) $display("FAIL t2_stat_sym got=%0d exp=16", sc_stat_sym); else passed++;
`endif
    pop_one();
    checks++; if (obs() !== 66'd0) $display("FAIL t2_drained got=%h exp=0", obs()); else passed++;
  endtask

  task automatic test_five_runs();
    logic [65:0] exp_a, exp_b;
    drive(4'b0001, 10'd1, 10'd0, 10'd0, 10'd0, 8'd3, MIDDLE);
    drive(4'b1111, 10'd2, 10'd3, 10'd4, 10'd5, 8'd3, END);
    step();
    exp_a = {4'b1111, 10'd1, 10'd2, 10'd3, 10'd4, 3'd1, 3'd1, 3'd1, 3'd1, 8'd3, MIDDLE};
    exp_b = {4'b0001, 10'd5, 30'd0, 3'd1, 9'd0, 8'd3, END};
    checks++; if (obs() !== exp_a) $display("FAIL t3_beat_a got=%h exp=%h", obs(), exp_a); else passed++;
    step();
    checks++; if (obs() !== exp_a) $display("FAIL t3_hold got=%h exp=%h", obs(), exp_a); else passed++;
    pop_one();
    checks++; if (obs() !== exp_b) $display("FAIL t3_beat_b got=%h exp=%h", obs(), exp_b); else passed++;
    pop_one();
    checks++; if (obs() !== 66'd0) $display("FAIL t3_drained got=%h exp=0", obs()); else passed++;
  endtask

  task automatic test_sparse_lanes();
    logic [65:0] exp;
    drive(4'b1010, 10'd99, 10'd7, 10'd55, 10'd7, 8'd4, MIDDLE);
    drive(4'b0000, 10'd0, 10'd0, 10'd0, 10'd0, 8'd4, END);
    step();
    exp = {4'b0001, 10'd7, 30'd0, 3'd2, 9'd0, 8'd4, END};
    checks++; if (obs() !== exp) $display("FAIL t4_sparse got=%h exp=%h", obs(), exp); else passed++;
    pop_one();
    checks++; if (obs() !== 66'd0) $display("FAIL t4_drained got=%h exp=0", obs()); else passed++;
  endtask

  task automatic test_empty_eob();
    logic [65:0] exp;
    drive(4'b0000, 10'd0, 10'd0, 10'd0, 10'd0, 8'd5, TRUNC);
    step();
    exp = {4'b0001, 40'd0, 12'd0, 8'd5, TRUNC};
    checks++; if (obs() !== exp) $display("FAIL t5_empty_eob got=%h exp=%h", obs(), exp); else passed++;
    pop_one();
    checks++; if (obs() !== 66'd0) $display("FAIL t5_drained got=%h exp=0", obs()); else passed++;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    logic [65:0] got[$];
    logic [65:0] exp;
    is_sc_rd = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (in_rdy && k < 6) begin
        in_vld = 4'b0001; in_sym0 = 10'(100 + k); in_seq_id = 8'(10 + k); in_eob = END;
        k++;
      end else begin
        in_vld = '0; in_eob = MIDDLE;
      end
      step();
    end
    in_vld = '0; in_eob = MIDDLE;
    checks++; if (k !== 3) $display("FAIL bp_accepted got=%0d exp=3", k); else passed++;
    checks++; if (in_rdy !== 1'b0) $display("FAIL bp_rdy_low got=%b exp=0", in_rdy); else passed++;
    is_sc_rd = 1'b1;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      if (sc_is_vld != 4'd0) got.push_back(obs());
      if (in_rdy && k < 6) begin
        in_vld = 4'b0001; in_sym0 = 10'(100 + k); in_seq_id = 8'(10 + k); in_eob = END;
        k++;
      end else begin
        in_vld = '0; in_eob = MIDDLE;
      end
      step();
    end
    is_sc_rd = 1'b0; in_vld = '0; in_eob = MIDDLE;
    checks++; if (got.size() !== 6) $display("FAIL bp_count got=%0d exp=6", got.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      exp = {4'b0001, 10'(100 + i), 30'd0, 3'd1, 9'd0, 8'(10 + i), END};
      if (i < got.size()) begin
        checks++; if (got[i] !== exp) $display("FAIL bp_beat%0d got=%h exp=%h", i, got[i], exp); else passed++;
      end
    end
    checks++; if (obs() !== 66'd0) $display("FAIL bp_drained got=%h exp=0", obs()); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [65:0] exp;
    is_sc_rd = 1'b0;
    drive(4'b0001, 10'd200, 10'd0, 10'd0, 10'd0, 8'd20, END);
    drive(4'b1111, 10'd1, 10'd2, 10'd3, 10'd4, 8'd20, MIDDLE);
    rst = 1'b1;
    step();
    checks++; if (obs() !== 66'd0) $display("FAIL rm_outputs got=%h exp=0", obs()); else passed++;
    checks++; if (in_rdy !== 1'b0) $display("FAIL rm_in_rdy got=%b exp=0", in_rdy); else passed++;
    rst = 1'b0;
    step();
    checks++; if (in_rdy !== 1'b1) $display("FAIL rm_rdy_after got=%b exp=1", in_rdy); else passed++;
    step();
    checks++; if (obs() !== 66'd0) $display("FAIL rm_no_partial got=%h exp=0", obs()); else passed++;
    drive(4'b0000, 10'd0, 10'd0, 10'd0, 10'd0, 8'd21, END);
    step();
    exp = {4'b0001, 40'd0, 12'd0, 8'd21, END};
    checks++; if (obs() !== exp) $display("FAIL rm_clean_eob got=%h exp=%h", obs(), exp); else passed++;
    pop_one();
    checks++; if (obs() !== 66'd0) $display("FAIL rm_drained got=%h exp=0", obs()); else passed++;
  endtask

  initial begin
    test_reset();
    test_run_split();
    test_saturate();
    test_five_runs();
    test_sparse_lanes();
    test_empty_eob();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
